// File: rtl/approx_product_decoder_pkg.sv
// ---------------------------------------------------------------------------
// approx_product_decoder_pkg
// Shared definitions for the approximate-product datapath. The operand
// encoder side reuses the same width helpers, so both ends of the encoding
// agree on how wide a shift amount is.
//   shamtWidth(bw)        : width of one operand's shift amount
//   sumShamtWidth(a, b)   : width of the summed shift amount (never wraps)
//   sign_e                : sign of a reconstructed product
// ---------------------------------------------------------------------------
package approx_product_decoder_pkg;

  // Width of an operand shift amount for a bw-bit operand. Clamped to one
  // bit so a degenerate 1-bit operand still gets a legal vector.
  function automatic int shamtWidth(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

  // One extra bit over the wider operand's shift field, so that
  // a_shamt + b_shamt always fits.
  function automatic int sumShamtWidth(input int aBw, input int bBw);
    return shamtWidth((aBw > bBw) ? aBw : bBw) + 1;
  endfunction

  typedef enum logic {
    SIGN_POS = 1'b0,
    SIGN_NEG = 1'b1
  } sign_e;

endpackage

// File: rtl/approx_product_decoder_shift_sat.sv
// ---------------------------------------------------------------------------
// approx_shift_sat
// Combinational core of the product decoder: shifts the unsigned multiplier
// product back up to full magnitude, applies the sign, and saturates to the
// signed OUT_BW range.
//   multProd_i : unsigned accurate multiplier product (2*MULT_DW bits)
//   sign_i     : sign of the product
//   shamt_i    : total left-shift amount
//   prod_o     : signed, saturated product (OUT_BW bits)
//   ovf_o      : high when prod_o was saturated
// ---------------------------------------------------------------------------
module approx_shift_sat
  import approx_product_decoder_pkg::*;
#(
  parameter int MULT_DW = 4,
  parameter int SH_W    = 4,
  parameter int OUT_BW  = 16
) (
  input  logic [2*MULT_DW-1:0] multProd_i,
  input  sign_e                sign_i,
  input  logic [SH_W-1:0]      shamt_i,
  output logic [OUT_BW-1:0]    prod_o,
  output logic                 ovf_o
);

  // Wide enough to hold the largest possible shift without losing any bit,
  // so the comparison against the limits sees the true magnitude.
  localparam int MAG_W = OUT_BW + 2*MULT_DW + (1 << SH_W);

  localparam logic [MAG_W-1:0]  POS_LIM = (MAG_W'(1) << (OUT_BW-1)) - MAG_W'(1);
  localparam logic [MAG_W-1:0]  NEG_LIM = MAG_W'(1) << (OUT_BW-1);
  localparam logic [OUT_BW-1:0] POS_SAT = {1'b0, {(OUT_BW-1){1'b1}}};
  localparam logic [OUT_BW-1:0] NEG_SAT = {1'b1, {(OUT_BW-1){1'b0}}};

  logic [MAG_W-1:0] mag;

  // Rebuild the magnitude, then clamp. The negative side may reach one
  // further than the positive side; negating exactly 2^(OUT_BW-1) in
  // OUT_BW bits yields the most negative value, which is the right answer.
  always_comb begin
    mag    = MAG_W'(multProd_i) << shamt_i;
    prod_o = '0;
    ovf_o  = 1'b0;
    if (sign_i == SIGN_POS) begin
      if (mag > POS_LIM) begin
        prod_o = POS_SAT;
        ovf_o  = 1'b1;
      end else begin
        prod_o = mag[OUT_BW-1:0];
      end
    end else begin
      if (mag > NEG_LIM) begin
        prod_o = NEG_SAT;
        ovf_o  = 1'b1;
      end else begin
        prod_o = -mag[OUT_BW-1:0];
      end
    end
  end

endmodule

// File: rtl/approx_product_decoder.sv
// ---------------------------------------------------------------------------
// approx_product_decoder
// Reconstructs the signed product from the small accurate multiplier of the
// approximate datapath: (-1)^(a_sign^b_sign) * (mult_prod << (a_shamt+b_shamt)).
// Two-stage valid/ready pipeline with saturation and overflow reporting.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake
//   mult_prod           : unsigned multiplier product
//   a_sign, b_sign      : operand signs (1 = negative)
//   a_shamt, b_shamt    : operand shift amounts
//   out_valid/out_ready : output handshake
//   out_prod, out_ovf   : signed result and its saturation flag
//   ovf_sticky          : any saturated result was delivered since reset
// ---------------------------------------------------------------------------
module approx_product_decoder
  import approx_product_decoder_pkg::*;
#(
  parameter int MULT_DW = 4,
  parameter int A_BW    = 8,
  parameter int B_BW    = 8,
  parameter int OUT_BW  = A_BW + B_BW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*MULT_DW-1:0]        mult_prod,
  input  logic                        a_sign,
  input  logic                        b_sign,
  input  logic [shamtWidth(A_BW)-1:0] a_shamt,
  input  logic [shamtWidth(B_BW)-1:0] b_shamt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_BW-1:0]           out_prod,
  output logic                        out_ovf,
  output logic                        ovf_sticky
);

  localparam int SH_W = sumShamtWidth(A_BW, B_BW);

  logic                 adv1, adv2;

  logic                 s1Valid_q, s1Valid_d;
  logic [2*MULT_DW-1:0] s1Prod_q,  s1Prod_d;
  sign_e                s1Sign_q,  s1Sign_d;
  logic [SH_W-1:0]      s1Shamt_q, s1Shamt_d;

  logic                 s2Valid_q, s2Valid_d;
  logic [OUT_BW-1:0]    s2Prod_q,  s2Prod_d;
  logic                 s2Ovf_q,   s2Ovf_d;
  logic                 sticky_q,  sticky_d;

  logic [OUT_BW-1:0]    shiftProd;
  logic                 shiftOvf;

  approx_shift_sat #(
    .MULT_DW (MULT_DW),
    .SH_W    (SH_W),
    .OUT_BW  (OUT_BW)
  ) u_shift_sat (
    .multProd_i (s1Prod_q),
    .sign_i     (s1Sign_q),
    .shamt_i    (s1Shamt_q),
    .prod_o     (shiftProd),
    .ovf_o      (shiftOvf)
  );

  // A stage may move when it is empty or when the stage after it is moving;
  // in_ready is purely a function of pipeline state and out_ready.
  assign adv2     = !s2Valid_q || out_ready;
  assign adv1     = !s1Valid_q || adv2;
  assign in_ready = adv1;

  // Next-state for both stages. Payload registers only load when a real
  // beat moves in, so a stalled stage keeps its data untouched.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Prod_d  = s1Prod_q;
    s1Sign_d  = s1Sign_q;
    s1Shamt_d = s1Shamt_q;
    s2Valid_d = s2Valid_q;
    s2Prod_d  = s2Prod_q;
    s2Ovf_d   = s2Ovf_q;
    sticky_d  = sticky_q;

    if (adv1) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Prod_d  = mult_prod;
        s1Sign_d  = sign_e'(a_sign ^ b_sign);
        s1Shamt_d = SH_W'(a_shamt) + SH_W'(b_shamt);
      end
    end

    if (adv2) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Prod_d = shiftProd;
        s2Ovf_d  = shiftOvf;
      end
    end

    if (s2Valid_q && out_ready && s2Ovf_q) begin
      sticky_d = 1'b1;
    end
  end

  // All state updates on the rising edge; reset drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Prod_q  <= '0;
      s1Sign_q  <= SIGN_POS;
      s1Shamt_q <= '0;
      s2Valid_q <= 1'b0;
      s2Prod_q  <= '0;
      s2Ovf_q   <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Prod_q  <= s1Prod_d;
      s1Sign_q  <= s1Sign_d;
      s1Shamt_q <= s1Shamt_d;
      s2Valid_q <= s2Valid_d;
      s2Prod_q  <= s2Prod_d;
      s2Ovf_q   <= s2Ovf_d;
      sticky_q  <= sticky_d;
    end
  end

  assign out_valid  = s2Valid_q;
  assign out_prod   = s2Prod_q;
  assign out_ovf    = s2Ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_approx_product_decoder.sv
// ---------------------------------------------------------------------------
// tb_approx_product_decoder
// Directed-vector bench for approx_product_decoder with a scoreboard queue:
// the driver pushes the hand-computed expected result when a beat is
// accepted, and an independent monitor pops and compares on every output
// transfer.
// ---------------------------------------------------------------------------
module tb_approx_product_decoder;

  typedef struct {
    int prod;
    int ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mult_prod;
  logic       a_sign;
  logic       b_sign;
  logic [2:0] a_shamt;
  logic [2:0] b_shamt;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] out_prod;
  logic       out_ovf;
  logic       ovf_sticky;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;

  approx_product_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mult_prod  (mult_prod),
    .a_sign     (a_sign),
    .b_sign     (b_sign),
    .a_shamt    (a_shamt),
    .b_shamt    (b_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky)
  );

  // 10 time-unit clock; inputs change on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and count it.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Present one beat and hold it until accepted, then push its expected result.
  task automatic applyStimulus(input int prod, input bit aS, input bit bS,
                               input int aSh, input int bSh,
                               input int expProd, input int expOvf);
    int   waited;
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    mult_prod = 8'(prod);
    a_sign    = aS;
    b_sign    = bS;
    a_shamt   = 3'(aSh);
    b_shamt   = 3'(bSh);
    waited    = 0;
    #1;
    while (!in_ready) begin
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: beat %0d not accepted, expected in_ready=1", prod);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    e.prod = expProd;
    e.ovf  = expOvf;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every pushed beat has been delivered.
  task automatic drainWait();
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d beats pending, expected 0", sbQ.size());
    end
  endtask

  // Monitor: just before each rising edge, a valid&&ready output is a transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0d, expected no output", $signed(out_prod));
        end else begin
          e = sbQ.pop_front();
          checkOutput("sb_prod", int'($signed(out_prod)), e.prod);
          checkOutput("sb_ovf", int'(out_ovf), e.ovf);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mult_prod = '0;
    a_sign    = 1'b0;
    b_sign    = 1'b0;
    a_shamt   = '0;
    b_shamt   = '0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_prod", int'(out_prod), 0);
    checkOutput("rst_out_ovf", int'(out_ovf), 0);
    checkOutput("rst_sticky", int'(ovf_sticky), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);

    // Simple positive beat with latency check.
    applyStimulus(15, 0, 0, 0, 0, 15, 0);
    #3;
    checkOutput("lat1_cycle1_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("lat1_cycle2_valid", int'(out_valid), 1);
    drainWait();

    // Negative product in range and boundary magnitudes.
    applyStimulus(225, 1, 0, 3, 3, -14400, 0);
    applyStimulus(255, 0, 0, 7, 0, 32640, 0);
    applyStimulus(128, 1, 0, 4, 4, -32768, 0);
    drainWait();
    checkOutput("sticky_before_sat", int'(ovf_sticky), 0);

    // Saturation both ways, plus a shift far past OUT_BW.
    applyStimulus(225, 0, 0, 4, 4, 32767, 1);
    applyStimulus(225, 1, 0, 4, 4, -32768, 1);
    applyStimulus(128, 0, 0, 4, 4, 32767, 1);
    applyStimulus(255, 0, 1, 7, 7, -32768, 1);
    applyStimulus(255, 1, 1, 7, 7, 32767, 1);
    applyStimulus(0, 1, 0, 7, 7, 0, 0);
    drainWait();
    checkOutput("sticky_after_sat", int'(ovf_sticky), 1);

    // Back-to-back beats against a 5-cycle downstream stall.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) applyStimulus(i, 0, 0, 0, 0, i, 0);
      end
      begin
        repeat (3) @(negedge clk);
        #3;
        checkOutput("stall_in_ready", int'(in_ready), 0);
        checkOutput("stall_out_valid", int'(out_valid), 1);
        checkOutput("stall_hold_c3", int'(out_prod), 1);
        @(negedge clk);
        #3;
        checkOutput("stall_hold_c4", int'(out_prod), 1);
        @(negedge clk);
        #3;
        checkOutput("stall_hold_c5", int'(out_prod), 1);
        checkOutput("stall_in_ready_c5", int'(in_ready), 0);
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
          if (k > 1) @(negedge clk);
          #3;
          checkOutput("stream_valid", int'(out_valid), 1);
          checkOutput("stream_prod", int'(out_prod), k);
        end
      end
    join
    drainWait();

    // Reset with a full pipeline and the sticky flag set.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(5, 0, 0, 0, 0, 5, 0);
    applyStimulus(6, 0, 0, 0, 0, 6, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbQ.delete();
    checkOutput("rst2_out_valid", int'(out_valid), 0);
    checkOutput("rst2_sticky", int'(ovf_sticky), 0);
    checkOutput("rst2_out_prod", int'(out_prod), 0);
    checkOutput("rst2_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    applyStimulus(9, 0, 1, 1, 0, -18, 0);
    #3;
    checkOutput("lat2_cycle1_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("lat2_cycle2_valid", int'(out_valid), 1);
    drainWait();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
